// File: rtl/sonic_rx_ring_ctl.sv
// RX ring buffer between block-sync and DMA: stores blocks, tracks occupancy from
// write/read pointers, and serves reads either by host address (DMA) or in order (FIFO).
module sonic_rx_ring_ctl #(
   parameter int DATA_WIDTH    = 66,
   parameter int ADDR_WIDTH    = 13,
   parameter int AFULL_THRESH  = (2**ADDR_WIDTH) - 64,
   parameter int AEMPTY_THRESH = 8,
   parameter bit AUTO_ADVANCE  = 1'b0,
   parameter int CNT_WIDTH     = 32
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  wrena,
   input  logic                  wrreq,
   input  logic                  rdena,
   input  logic                  rdreq,
   input  logic [ADDR_WIDTH-1:0] rd_address,
   input  logic                  host_rptr_wr,
   input  logic [ADDR_WIDTH:0]   host_rptr,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  data_out_valid,
   output logic [ADDR_WIDTH:0]   rx_ring_wptr,
   output logic [ADDR_WIDTH:0]   usedw,
   output logic                  full,
   output logic                  almost_full,
   output logic                  empty,
   output logic                  almost_empty,
   output logic [CNT_WIDTH-1:0]  overflow_count,
   output logic                  rptr_err
);

   localparam int PW = ADDR_WIDTH + 1;
   localparam int DEPTH = 2**ADDR_WIDTH;
   localparam logic [PW-1:0] DEPTH_P  = PW'(DEPTH);
   localparam logic [PW-1:0] AFULL_P  = PW'(AFULL_THRESH);
   localparam logic [PW-1:0] AEMPTY_P = PW'(AEMPTY_THRESH);
   localparam logic [PW-1:0] PTR_ONE  = PW'(1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]         wptr;
   logic [PW-1:0]         rptr;
   logic [PW-1:0]         host_dist;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic                  wr_acc;
   logic                  wr_drop;
   logic                  rd_acc;

   // Pointers carry an extra wrap bit so a difference of DEPTH (full) never aliases to 0 (empty).
   assign usedw        = wptr - rptr;
   assign full         = (usedw == DEPTH_P);
   assign empty        = (usedw == '0);
   assign almost_full  = (usedw >= AFULL_P);
   assign almost_empty = (usedw <= AEMPTY_P);
   assign rx_ring_wptr = wptr;

   assign wr_acc    = wrena & wrreq & ~full;
   assign wr_drop   = wrena & wrreq & full;
   assign rd_acc    = rdena & rdreq & ~empty;
   assign host_dist = wptr - host_rptr;
   assign rd_addr   = AUTO_ADVANCE ? rptr[ADDR_WIDTH-1:0] : rd_address;

   // RAM is never cleared; the registered read yields old contents on a same-address write.
   always_ff @(posedge clock) begin
      if (wr_acc) begin
         mem[wptr[ADDR_WIDTH-1:0]] <= data_in;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         data_out       <= '0;
         data_out_valid <= 1'b0;
      end else begin
         data_out_valid <= rd_acc;
         if (rd_acc) begin
            data_out <= mem[rd_addr];
         end
      end
   end

   // A host pointer farther than DEPTH behind wptr would imply more data than the ring holds.
   always_ff @(posedge clock) begin
      if (reset) begin
         wptr           <= '0;
         rptr           <= '0;
         overflow_count <= '0;
         rptr_err       <= 1'b0;
      end else begin
         if (wr_acc) begin
            wptr <= wptr + PTR_ONE;
         end
         if (wr_drop && (overflow_count != CNT_MAX)) begin
            overflow_count <= overflow_count + CNT_ONE;
         end
         if (AUTO_ADVANCE) begin
            if (rd_acc) begin
               rptr <= rptr + PTR_ONE;
            end
         end else if (host_rptr_wr) begin
            if (host_dist <= DEPTH_P) begin
               rptr <= host_rptr;
            end else begin
               rptr_err <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_sonic_rx_ring_ctl.sv
// Directed bench: one DMA-mode and one FIFO-mode ring, driven by hand-computed vectors.
module tb_sonic_rx_ring_ctl;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   int pass_cnt = 0;
   int total_cnt = 0;
   int fail_cnt = 0;

   // DMA-mode instance signals
   logic [65:0] d_data_in = '0;
   logic        d_wrena = 1'b0, d_wrreq = 1'b0, d_rdena = 1'b0, d_rdreq = 1'b0;
   logic [12:0] d_rd_address = '0;
   logic        d_host_wr = 1'b0;
   logic [13:0] d_host_rptr = '0;
   logic [65:0] d_data_out;
   logic        d_valid, d_full, d_afull, d_empty, d_aempty, d_err;
   logic [13:0] d_wptr, d_usedw;
   logic [31:0] d_ovf;

   // FIFO-mode instance signals
   logic [65:0] f_data_in = '0;
   logic        f_wrena = 1'b0, f_wrreq = 1'b0, f_rdena = 1'b0, f_rdreq = 1'b0;
   logic        f_host_wr = 1'b0;
   logic [13:0] f_host_rptr = '0;
   logic [65:0] f_data_out;
   logic        f_valid, f_full, f_afull, f_empty, f_aempty, f_err;
   logic [13:0] f_wptr, f_usedw;
   logic [31:0] f_ovf;

   sonic_rx_ring_ctl #(.AUTO_ADVANCE(1'b0)) dut_dma (
      .clock(clock), .reset(reset), .data_in(d_data_in), .wrena(d_wrena), .wrreq(d_wrreq),
      .rdena(d_rdena), .rdreq(d_rdreq), .rd_address(d_rd_address), .host_rptr_wr(d_host_wr),
      .host_rptr(d_host_rptr), .data_out(d_data_out), .data_out_valid(d_valid),
      .rx_ring_wptr(d_wptr), .usedw(d_usedw), .full(d_full), .almost_full(d_afull),
      .empty(d_empty), .almost_empty(d_aempty), .overflow_count(d_ovf), .rptr_err(d_err)
   );

   sonic_rx_ring_ctl #(.AUTO_ADVANCE(1'b1)) dut_fifo (
      .clock(clock), .reset(reset), .data_in(f_data_in), .wrena(f_wrena), .wrreq(f_wrreq),
      .rdena(f_rdena), .rdreq(f_rdreq), .rd_address(13'd0), .host_rptr_wr(f_host_wr),
      .host_rptr(f_host_rptr), .data_out(f_data_out), .data_out_valid(f_valid),
      .rx_ring_wptr(f_wptr), .usedw(f_usedw), .full(f_full), .almost_full(f_afull),
      .empty(f_empty), .almost_empty(f_aempty), .overflow_count(f_ovf), .rptr_err(f_err)
   );

   function automatic logic [65:0] val(input int i);
      logic [31:0] u;
      u = i;
      if (i == 7) return 66'h2_DEAD_BEEF;
      return {2'b01, 32'hA5A5_0000 ^ u, u};
   endfunction

   task automatic step;
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic d_write(input int i);
      d_data_in = val(i);
      d_wrena = 1'b1;
      d_wrreq = 1'b1;
      step();
      d_wrreq = 1'b0;
   endtask

   task automatic d_read(input int addr);
      d_rd_address = 13'(addr);
      d_rdreq = 1'b1;
      step();
      d_rdreq = 1'b0;
      check("dma_rd_valid", 66'(d_valid), 66'd1);
      check("dma_rd_data", d_data_out, val(addr));
   endtask

   initial begin
      d_rdena = 1'b1;
      f_rdena = 1'b1;
      f_wrena = 1'b1;
      step();
      step();
      reset = 1'b0;
      check("rst_usedw", 66'(d_usedw), 66'd0);
      check("rst_empty", 66'(d_empty), 66'd1);
      check("rst_aempty", 66'(d_aempty), 66'd1);
      check("rst_full", 66'(d_full), 66'd0);
      check("rst_afull", 66'(d_afull), 66'd0);
      check("rst_wptr", 66'(d_wptr), 66'd0);
      check("rst_valid", 66'(d_valid), 66'd0);
      check("rst_dout", d_data_out, 66'd0);
      check("rst_ovf", 66'(d_ovf), 66'd0);
      check("rst_err", 66'(d_err), 66'd0);

      // ---- DMA mode ----
      for (int i = 0; i < 5; i++) d_write(i);
      check("w5_usedw", 66'(d_usedw), 66'd5);
      check("w5_wptr", 66'(d_wptr), 66'd5);
      check("w5_empty", 66'(d_empty), 66'd0);
      check("w5_aempty", 66'(d_aempty), 66'd1);
      for (int i = 5; i < 8; i++) d_write(i);
      check("w8_aempty", 66'(d_aempty), 66'd1);
      d_write(8);
      check("w9_aempty", 66'(d_aempty), 66'd0);

      d_read(7);
      check("rd7_usedw", 66'(d_usedw), 66'd9);
      step();
      check("rd7_pulse_end", 66'(d_valid), 66'd0);
      check("rd7_hold", d_data_out, 66'h2_DEAD_BEEF);

      d_wrena = 1'b0;
      d_wrreq = 1'b1;
      step();
      d_wrreq = 1'b0;
      check("wrena0_usedw", 66'(d_usedw), 66'd9);

      for (int i = 9; i < 100; i++) d_write(i);
      check("w100_usedw", 66'(d_usedw), 66'd100);
      d_host_rptr = 14'd60;
      d_host_wr = 1'b1;
      step();
      check("host60_usedw", 66'(d_usedw), 66'd40);
      check("host60_err", 66'(d_err), 66'd0);
      d_host_rptr = 14'd120;
      step();
      check("host120_usedw", 66'(d_usedw), 66'd40);
      check("host120_err", 66'(d_err), 66'd1);
      d_host_rptr = 14'd0;
      step();
      d_host_wr = 1'b0;
      check("host0_usedw", 66'(d_usedw), 66'd100);
      check("err_sticky", 66'(d_err), 66'd1);

      for (int i = 100; i < 8127; i++) d_write(i);
      check("af_below", 66'(d_afull), 66'd0);
      d_write(8127);
      check("af_at", 66'(d_afull), 66'd1);
      for (int i = 8128; i < 8191; i++) d_write(i);
      check("full_before", 66'(d_full), 66'd0);
      d_write(8191);
      check("full_set", 66'(d_full), 66'd1);
      check("full_usedw", 66'(d_usedw), 66'd8192);
      for (int i = 0; i < 3; i++) begin
         d_data_in = '1;
         d_wrreq = 1'b1;
         step();
      end
      d_wrreq = 1'b0;
      check("ovf_count", 66'(d_ovf), 66'd3);
      check("ovf_usedw", 66'(d_usedw), 66'd8192);
      check("ovf_wptr", 66'(d_wptr), 66'h2000);
      d_read(0);
      d_read(1);
      d_read(4095);
      d_read(8191);

      d_host_rptr = 14'h2000;
      d_host_wr = 1'b1;
      step();
      d_host_wr = 1'b0;
      check("drain_empty", 66'(d_empty), 66'd1);
      d_rdreq = 1'b1;
      step();
      d_rdreq = 1'b0;
      check("empty_rd_novalid", 66'(d_valid), 66'd0);

      // ---- FIFO mode ----
      for (int i = 0; i < 10; i++) begin
         f_data_in = 66'(i);
         f_wrreq = 1'b1;
         step();
      end
      f_wrreq = 1'b0;
      check("f_usedw10", 66'(f_usedw), 66'd10);
      f_host_rptr = 14'd5;
      f_host_wr = 1'b1;
      step();
      f_host_wr = 1'b0;
      check("f_host_ignored", 66'(f_usedw), 66'd10);
      f_rdreq = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         check("f_rd_valid", 66'(f_valid), 66'd1);
         check("f_rd_data", f_data_out, 66'(i));
      end
      check("f_empty", 66'(f_empty), 66'd1);
      step();
      f_rdreq = 1'b0;
      check("f_rd11_novalid", 66'(f_valid), 66'd0);
      check("f_rd11_hold", f_data_out, 66'd9);

      reset = 1'b1;
      step();
      reset = 1'b0;
      check("f_rst_wptr", 66'(f_wptr), 66'd0);
      for (int k = 1; k <= 9000; k++) begin
         f_data_in = 66'(k * 5 + 3);
         f_wrreq = 1'b1;
         f_rdreq = 1'b0;
         step();
         check("wrap_usedw_w", 66'(f_usedw), 66'd1);
         if (k == 8191) check("wrap_bit_before", 66'(f_wptr[13]), 66'd0);
         if (k == 8192) check("wrap_bit_after", 66'(f_wptr[13]), 66'd1);
         f_wrreq = 1'b0;
         f_rdreq = 1'b1;
         step();
         check("wrap_data", f_data_out, 66'(k * 5 + 3));
         check("wrap_usedw_r", 66'(f_usedw), 66'd0);
      end
      f_rdreq = 1'b0;

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
